// File: rtl/pipe_tag_if.sv
// -----------------------------------------------------------------------------
// pipe_tag_if
//   Signal bundle between the CPU pipeline control (fetch enable, hazard stall,
//   branch flush) and the pipe_tag_sequencer. The sequencer sits on the slave
//   side; whoever drives the pipeline controls uses the master side.
//
//   Control (master -> slave): fetch_en, stall, flush
//   Fetch   (slave -> master): fetch_vld, fetch_tag
//   Slots   (slave -> master): {dec,ex,mem,wb}_vld, {dec,ex,mem,wb}_tag,
//                              wb_flushed, in_flight
//   Stats   (slave -> master): retire_cnt, flush_cnt, stall_cnt
// -----------------------------------------------------------------------------
interface pipe_tag_if #(
  parameter int TAG_W = 7,
  parameter int CNT_W = 16
);
  logic             fetch_en;
  logic             stall;
  logic             flush;

  logic             fetch_vld;
  logic [TAG_W-1:0] fetch_tag;

  logic             dec_vld;
  logic             ex_vld;
  logic             mem_vld;
  logic             wb_vld;
  logic [TAG_W-1:0] dec_tag;
  logic [TAG_W-1:0] ex_tag;
  logic [TAG_W-1:0] mem_tag;
  logic [TAG_W-1:0] wb_tag;
  logic             wb_flushed;
  logic [2:0]       in_flight;

  logic [CNT_W-1:0] retire_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport slave (
    input  fetch_en, stall, flush,
    output fetch_vld, fetch_tag,
    output dec_vld, ex_vld, mem_vld, wb_vld,
    output dec_tag, ex_tag, mem_tag, wb_tag,
    output wb_flushed, in_flight,
    output retire_cnt, flush_cnt, stall_cnt
  );

  modport master (
    output fetch_en, stall, flush,
    input  fetch_vld, fetch_tag,
    input  dec_vld, ex_vld, mem_vld, wb_vld,
    input  dec_tag, ex_tag, mem_tag, wb_tag,
    input  wb_flushed, in_flight,
    input  retire_cnt, flush_cnt, stall_cnt
  );
endinterface

// File: rtl/pipe_tag_sequencer.sv
// -----------------------------------------------------------------------------
// pipe_tag_sequencer
//   Issues a rolling tag (0..DEPTH-1) to every fetched instruction and carries
//   {vld, tag, flushed} through the IF/ID, ID/EX, EX/MEM and MEM/WB slots in
//   lock-step with the CPU pipeline, applying stall and flush the same way the
//   hazard unit does. Saturating statistics counters track retirements,
//   flushed retirements and stall cycles.
//
//   Ports:
//     clk  - clock, all state updates on the rising edge
//     rst  - synchronous active-high reset
//     bus  - pipe_tag_if.slave: fetch_en/stall/flush in; fetch, per-stage slot,
//            in_flight and counter outputs out
//
//   Parameters:
//     DEPTH - number of distinct tags (8..128); tags wrap modulo DEPTH
//     TAG_W - tag width, 2**TAG_W >= DEPTH
//     CNT_W - statistics counter width
// -----------------------------------------------------------------------------
module pipe_tag_sequencer #(
  parameter int DEPTH = 72,
  parameter int TAG_W = 7,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  pipe_tag_if.slave  bus
);

  // At most four tags are ever in flight, so DEPTH >= 8 keeps every live tag
  // unique; anything outside the legal range is rejected at elaboration.
  if (DEPTH < 8 || DEPTH > 128 || (2 ** TAG_W) < DEPTH) begin : g_param_check
    $error("pipe_tag_sequencer: DEPTH must be 8..128 and fit in TAG_W bits");
  end

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic             flushed;
  } slot_t;

  localparam logic [TAG_W-1:0] LAST_TAG = TAG_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [TAG_W-1:0] next_tag;
  slot_t            if_id, id_ex, ex_mem, mem_wb;
  logic [CNT_W-1:0] retire_cnt, flush_cnt, stall_cnt;

  logic fetch_vld;
  logic bubble;

  // A flush squashes the incoming instruction but still lets it advance, so
  // it overrides a simultaneous stall everywhere: tag issue, IF/ID and ID/EX.
  assign fetch_vld = bus.fetch_en & (~bus.stall | bus.flush);
  assign bubble    = bus.stall & ~bus.flush;

  // NOTE: every register below is updated with non-blocking assignments so
  // all slots shift on the same edge using their pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      next_tag   <= '0;
      if_id      <= '0;
      id_ex      <= '0;
      ex_mem     <= '0;
      mem_wb     <= '0;
      retire_cnt <= '0;
      flush_cnt  <= '0;
      stall_cnt  <= '0;
    end else begin
      if (fetch_vld) begin
        next_tag <= (next_tag == LAST_TAG) ? '0 : next_tag + TAG_W'(1);
      end

      if (bus.flush) begin
        if_id <= '{vld: bus.fetch_en, tag: next_tag, flushed: 1'b1};
      end else if (!bus.stall) begin
        if_id <= '{vld: bus.fetch_en, tag: next_tag, flushed: 1'b0};
      end

      id_ex  <= bubble ? '0 : if_id;
      ex_mem <= id_ex;
      mem_wb <= ex_mem;

      // Counters stick at all-ones rather than wrapping.
      if (mem_wb.vld && !mem_wb.flushed && retire_cnt != CNT_MAX) begin
        retire_cnt <= retire_cnt + CNT_W'(1);
      end
      if (mem_wb.vld && mem_wb.flushed && flush_cnt != CNT_MAX) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
      if (bubble && stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.fetch_vld  = fetch_vld;
  assign bus.fetch_tag  = next_tag;

  assign bus.dec_vld    = if_id.vld;
  assign bus.dec_tag    = if_id.tag;
  assign bus.ex_vld     = id_ex.vld;
  assign bus.ex_tag     = id_ex.tag;
  assign bus.mem_vld    = ex_mem.vld;
  assign bus.mem_tag    = ex_mem.tag;
  assign bus.wb_vld     = mem_wb.vld;
  assign bus.wb_tag     = mem_wb.tag;
  assign bus.wb_flushed = mem_wb.flushed;

  assign bus.in_flight  = {2'b00, if_id.vld} + {2'b00, id_ex.vld}
                        + {2'b00, ex_mem.vld} + {2'b00, mem_wb.vld};

  assign bus.retire_cnt = retire_cnt;
  assign bus.flush_cnt  = flush_cnt;
  assign bus.stall_cnt  = stall_cnt;

endmodule

// File: tb/tb_pipe_tag_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pipe_tag_sequencer
//   Two sequencers driven by the same controls: A (DEPTH=72, CNT_W=16) and
//   B (DEPTH=8, CNT_W=4, so tag wrap and counter saturation happen quickly).
//   A reference model keeps each pipeline as an array of four instruction
//   records and derives tags as (fetch count mod DEPTH).
// -----------------------------------------------------------------------------
module tb_pipe_tag_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic fe_r, st_r, fl_r;

  always #5 clk = ~clk;

  pipe_tag_if #(.TAG_W(7), .CNT_W(16)) bus_a ();
  pipe_tag_if #(.TAG_W(7), .CNT_W(4))  bus_b ();

  assign bus_a.fetch_en = fe_r;
  assign bus_a.stall    = st_r;
  assign bus_a.flush    = fl_r;
  assign bus_b.fetch_en = fe_r;
  assign bus_b.stall    = st_r;
  assign bus_b.flush    = fl_r;

  pipe_tag_sequencer #(.DEPTH(72), .TAG_W(7), .CNT_W(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  pipe_tag_sequencer #(.DEPTH(8), .TAG_W(7), .CNT_W(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- observe
  typedef struct {
    logic [31:0] fv, ft, dv, dt, xv, xt, mv, mt, wv, wt, wf, inf, ret, fcnt, scnt;
  } obs_t;

  function automatic obs_t sample(input int m);
    obs_t o;
    if (m == 0) begin
      o.fv = 32'(bus_a.fetch_vld);  o.ft = 32'(bus_a.fetch_tag);
      o.dv = 32'(bus_a.dec_vld);    o.dt = 32'(bus_a.dec_tag);
      o.xv = 32'(bus_a.ex_vld);     o.xt = 32'(bus_a.ex_tag);
      o.mv = 32'(bus_a.mem_vld);    o.mt = 32'(bus_a.mem_tag);
      o.wv = 32'(bus_a.wb_vld);     o.wt = 32'(bus_a.wb_tag);
      o.wf = 32'(bus_a.wb_flushed); o.inf = 32'(bus_a.in_flight);
      o.ret = 32'(bus_a.retire_cnt); o.fcnt = 32'(bus_a.flush_cnt);
      o.scnt = 32'(bus_a.stall_cnt);
    end else begin
      o.fv = 32'(bus_b.fetch_vld);  o.ft = 32'(bus_b.fetch_tag);
      o.dv = 32'(bus_b.dec_vld);    o.dt = 32'(bus_b.dec_tag);
      o.xv = 32'(bus_b.ex_vld);     o.xt = 32'(bus_b.ex_tag);
      o.mv = 32'(bus_b.mem_vld);    o.mt = 32'(bus_b.mem_tag);
      o.wv = 32'(bus_b.wb_vld);     o.wt = 32'(bus_b.wb_tag);
      o.wf = 32'(bus_b.wb_flushed); o.inf = 32'(bus_b.in_flight);
      o.ret = 32'(bus_b.retire_cnt); o.fcnt = 32'(bus_b.flush_cnt);
      o.scnt = 32'(bus_b.stall_cnt);
    end
    return o;
  endfunction

  // ---------------------------------------------------------- reference model
  typedef struct {
    bit vld;
    int tag;
    bit fl;
  } ent_t;

  int   depth_m [2] = '{72, 8};
  int   cmax_m  [2] = '{65535, 15};
  ent_t pipe    [2][4];
  int   fetched [2];
  int   n_ret   [2];
  int   n_fl    [2];
  int   n_st    [2];

  function automatic int sat(input int n, input int m);
    return (n > cmax_m[m]) ? cmax_m[m] : n;
  endfunction

  task automatic model_reset(input int m);
    for (int s = 0; s < 4; s++) pipe[m][s] = '{1'b0, 0, 1'b0};
    fetched[m] = 0;
    n_ret[m]   = 0;
    n_fl[m]    = 0;
    n_st[m]    = 0;
  endtask

  task automatic model_step(input int m, input bit r, input bit fe, input bit st, input bit fl);
    bit hold;
    if (r) begin
      model_reset(m);
      return;
    end
    hold = st && !fl;
    if (pipe[m][3].vld) begin
      if (pipe[m][3].fl) n_fl[m]++;
      else               n_ret[m]++;
    end
    if (hold) n_st[m]++;
    pipe[m][3] = pipe[m][2];
    pipe[m][2] = pipe[m][1];
    pipe[m][1] = hold ? '{1'b0, 0, 1'b0} : pipe[m][0];
    if (!hold) pipe[m][0] = '{fe, fetched[m] % depth_m[m], fl};
    if (fe && (!st || fl)) fetched[m]++;
  endtask

  task automatic check_model(input int m);
    obs_t  o;
    string p;
    int    live, dup;
    int    tg [4];
    bit    vl [4];
    o = sample(m);
    p = (m == 0) ? "A" : "B";
    check({p, " fetch_tag"},  o.ft,  32'(fetched[m] % depth_m[m]));
    check({p, " dec_vld"},    o.dv,  32'(pipe[m][0].vld));
    check({p, " dec_tag"},    o.dt,  32'(pipe[m][0].tag));
    check({p, " ex_vld"},     o.xv,  32'(pipe[m][1].vld));
    check({p, " ex_tag"},     o.xt,  32'(pipe[m][1].tag));
    check({p, " mem_vld"},    o.mv,  32'(pipe[m][2].vld));
    check({p, " mem_tag"},    o.mt,  32'(pipe[m][2].tag));
    check({p, " wb_vld"},     o.wv,  32'(pipe[m][3].vld));
    check({p, " wb_tag"},     o.wt,  32'(pipe[m][3].tag));
    check({p, " wb_flushed"}, o.wf,  32'(pipe[m][3].fl));
    live = 0;
    for (int s = 0; s < 4; s++) live += int'(pipe[m][s].vld);
    check({p, " in_flight"},  o.inf, 32'(live));
    check({p, " retire_cnt"}, o.ret,  32'(sat(n_ret[m], m)));
    check({p, " flush_cnt"},  o.fcnt, 32'(sat(n_fl[m], m)));
    check({p, " stall_cnt"},  o.scnt, 32'(sat(n_st[m], m)));
    // Live tags across the four slots must never collide.
    vl = '{o.dv[0], o.xv[0], o.mv[0], o.wv[0]};
    tg = '{int'(o.dt), int'(o.xt), int'(o.mt), int'(o.wt)};
    dup = 0;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (vl[i] && vl[j] && tg[i] == tg[j]) dup++;
    check({p, " duplicate_tags"}, 32'(dup), 32'd0);
  endtask

  // One clock: drive controls, check the combinational fetch outputs, clock,
  // advance the model, check every registered output.
  task automatic tick(input bit r, input bit fe, input bit st, input bit fl);
    obs_t o;
    rst  = r;
    fe_r = fe;
    st_r = st;
    fl_r = fl;
    #1;
    for (int m = 0; m < 2; m++) begin
      o = sample(m);
      check((m == 0) ? "A fetch_vld" : "B fetch_vld", o.fv, 32'(fe && (!st || fl)));
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) model_step(m, r, fe, st, fl);
    #1;
    for (int m = 0; m < 2; m++) check_model(m);
  endtask

  // ------------------------------------------------------------ vector table
  typedef struct {
    bit r, fe, st, fl;
    int nx, dv, dt, xv, xt, mv, mt, wv, wt, ret, stl;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit r, input bit fe, input bit st, input bit fl,
                              input int nx, input int dv, input int dt, input int xv,
                              input int xt, input int mv, input int mt, input int wv,
                              input int wt, input int ret, input int stl);
    vec_t v;
    v = '{r, fe, st, fl, nx, dv, dt, xv, xt, mv, mt, wv, wt, ret, stl};
    return v;
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    obs_t o;
    bit   r, fe, st, fl;

    //            r fe st fl  nx dv dt xv xt mv mt wv wt ret stl
    // Six straight fetches, then drain: tags 0..5 retire on consecutive cycles.
    tbl.push_back(mk(1,0,0,0,  0, 0,0, 0,0, 0,0, 0,0, 0,0));
    tbl.push_back(mk(1,0,0,0,  0, 0,0, 0,0, 0,0, 0,0, 0,0));
    tbl.push_back(mk(0,1,0,0,  1, 1,0, 0,0, 0,0, 0,0, 0,0));
    tbl.push_back(mk(0,1,0,0,  2, 1,1, 1,0, 0,0, 0,0, 0,0));
    tbl.push_back(mk(0,1,0,0,  3, 1,2, 1,1, 1,0, 0,0, 0,0));
    tbl.push_back(mk(0,1,0,0,  4, 1,3, 1,2, 1,1, 1,0, 0,0));
    tbl.push_back(mk(0,1,0,0,  5, 1,4, 1,3, 1,2, 1,1, 1,0));
    tbl.push_back(mk(0,1,0,0,  6, 1,5, 1,4, 1,3, 1,2, 2,0));
    tbl.push_back(mk(0,0,0,0,  6, 0,6, 1,5, 1,4, 1,3, 3,0));
    tbl.push_back(mk(0,0,0,0,  6, 0,6, 0,6, 1,5, 1,4, 4,0));
    tbl.push_back(mk(0,0,0,0,  6, 0,6, 0,6, 0,6, 1,5, 5,0));
    tbl.push_back(mk(0,0,0,0,  6, 0,6, 0,6, 0,6, 0,6, 6,0));
    // Two stall cycles while tag 3 sits in IF/ID: two bubbles, fetch_tag holds 4.
    tbl.push_back(mk(1,0,0,0,  0, 0,0, 0,0, 0,0, 0,0, 0,0));
    tbl.push_back(mk(0,1,0,0,  1, 1,0, 0,0, 0,0, 0,0, 0,0));
    tbl.push_back(mk(0,1,0,0,  2, 1,1, 1,0, 0,0, 0,0, 0,0));
    tbl.push_back(mk(0,1,0,0,  3, 1,2, 1,1, 1,0, 0,0, 0,0));
    tbl.push_back(mk(0,1,0,0,  4, 1,3, 1,2, 1,1, 1,0, 0,0));
    tbl.push_back(mk(0,1,1,0,  4, 1,3, 0,0, 1,2, 1,1, 1,1));
    tbl.push_back(mk(0,1,1,0,  4, 1,3, 0,0, 0,0, 1,2, 2,2));
    tbl.push_back(mk(0,1,0,0,  5, 1,4, 1,3, 0,0, 0,0, 3,2));
    tbl.push_back(mk(0,0,0,0,  5, 0,5, 1,4, 1,3, 0,0, 3,2));
    tbl.push_back(mk(0,0,0,0,  5, 0,5, 0,5, 1,4, 1,3, 3,2));
    tbl.push_back(mk(0,0,0,0,  5, 0,5, 0,5, 0,5, 1,4, 4,2));
    tbl.push_back(mk(0,0,0,0,  5, 0,5, 0,5, 0,5, 0,5, 5,2));

    // Initial reset edge brings both DUTs and the model to a known state.
    rst  = 1'b1;
    fe_r = 1'b0;
    st_r = 1'b0;
    fl_r = 1'b0;
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) model_reset(m);

    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].r, tbl[i].fe, tbl[i].st, tbl[i].fl);
      o = sample(0);
      check($sformatf("vec%0d fetch_tag", i),  o.ft,   32'(tbl[i].nx));
      check($sformatf("vec%0d dec_vld", i),    o.dv,   32'(tbl[i].dv));
      check($sformatf("vec%0d dec_tag", i),    o.dt,   32'(tbl[i].dt));
      check($sformatf("vec%0d ex_vld", i),     o.xv,   32'(tbl[i].xv));
      check($sformatf("vec%0d ex_tag", i),     o.xt,   32'(tbl[i].xt));
      check($sformatf("vec%0d mem_vld", i),    o.mv,   32'(tbl[i].mv));
      check($sformatf("vec%0d mem_tag", i),    o.mt,   32'(tbl[i].mt));
      check($sformatf("vec%0d wb_vld", i),     o.wv,   32'(tbl[i].wv));
      check($sformatf("vec%0d wb_tag", i),     o.wt,   32'(tbl[i].wt));
      check($sformatf("vec%0d retire_cnt", i), o.ret,  32'(tbl[i].ret));
      check($sformatf("vec%0d stall_cnt", i),  o.scnt, 32'(tbl[i].stl));
    end

    // Flush with next_tag=7: tag 7 is squashed, reaches WB flagged, is counted
    // as a flush only. On the DEPTH=8 unit the same flush wraps next_tag to 0.
    tick(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) tick(0, 1, 0, 0);
    check("flush pre fetch_tag", sample(0).ft, 32'd7);
    tick(0, 1, 0, 1);
    o = sample(0);
    check("flush dec_vld",   o.dv, 32'd1);
    check("flush dec_tag",   o.dt, 32'd7);
    check("flush fetch_tag", o.ft, 32'd8);
    check("flush B wrap fetch_tag", sample(1).ft, 32'd0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
    o = sample(0);
    check("flush wb_vld",     o.wv, 32'd1);
    check("flush wb_tag",     o.wt, 32'd7);
    check("flush wb_flushed", o.wf, 32'd1);
    tick(0, 0, 0, 0);
    o = sample(0);
    check("flush flush_cnt",  o.fcnt, 32'd1);
    check("flush retire_cnt", o.ret,  32'd7);

    // Stall and flush together: flush wins, no bubble, no stall counted.
    tick(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 1, 0, 0);
    tick(0, 1, 1, 1);
    o = sample(0);
    check("stflush dec_vld",   o.dv,   32'd1);
    check("stflush dec_tag",   o.dt,   32'd3);
    check("stflush ex_vld",    o.xv,   32'd1);
    check("stflush ex_tag",    o.xt,   32'd2);
    check("stflush stall_cnt", o.scnt, 32'd0);
    check("stflush fetch_tag", o.ft,   32'd4);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
    o = sample(0);
    check("stflush wb_tag",     o.wt, 32'd3);
    check("stflush wb_flushed", o.wf, 32'd1);

    // DEPTH=8: twenty fetches give 0..7,0..7,0..3 and a full pipe.
    tick(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("wrap fetch_tag %0d", i), sample(1).ft, 32'(i % 8));
      tick(0, 1, 0, 0);
      if (i >= 3) check($sformatf("wrap in_flight %0d", i), sample(1).inf, 32'd4);
    end

    // Reset with four instructions in flight discards them without retiring.
    tick(1, 1, 0, 0);
    for (int m = 0; m < 2; m++) begin
      o = sample(m);
      check($sformatf("midrst%0d vld", m),
            {o.dv[0], o.xv[0], o.mv[0], o.wv[0]}, 32'd0);
      check($sformatf("midrst%0d in_flight", m),  o.inf,  32'd0);
      check($sformatf("midrst%0d retire_cnt", m), o.ret,  32'd0);
      check($sformatf("midrst%0d flush_cnt", m),  o.fcnt, 32'd0);
      check($sformatf("midrst%0d stall_cnt", m),  o.scnt, 32'd0);
      check($sformatf("midrst%0d fetch_tag", m),  o.ft,   32'd0);
    end

    // Randomised traffic, including occasional resets and long enough runs
    // to saturate the 4-bit counters of the DEPTH=8 unit.
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 299) == 0);
      fe = ($urandom_range(0, 9) < 8);
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 9) == 0);
      tick(r, fe, st, fl);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
